// File: rtl/ring_johnson_counter.sv
// ring_johnson_counter
//   Run-time selectable ring (one-hot) / Johnson (twisted-ring) counter used as
//   a multi-phase strobe generator. Supports bidirectional stepping, enable,
//   parallel load, a step index relative to the last seed/load point, a wrap
//   pulse and an illegal-code flag.
//
//   Optional feature macro: RINGCNT_SELFCORRECT_EN
//     defined   -> an enabled step taken on an illegal code reseeds the counter
//     undefined -> illegal codes shift like any other value
module ring_johnson_counter #(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [IDX_W-1:0] step_idx,
  output logic             wrap,
  output logic             illegal
);

  typedef enum logic {
    MODE_RING    = 1'b0,
    MODE_JOHNSON = 1'b1
  } mode_e;

  localparam logic [IDX_W-1:0] RING_LAST    = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] JOHNSON_LAST = IDX_W'(2*WIDTH - 1);

  mode_e            mode_in;
  mode_e            mode_q;
  logic [WIDTH-1:0] shifted;
  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] idx_next;
  logic             wrap_next;
  logic             fb_up;
  logic             fb_down;
  int               ones;
  int               edges;

  assign mode_in = mode_e'(mode);

  // Seed value of each mode: single one at bit 0 for ring, all zeros for Johnson.
  function automatic logic [WIDTH-1:0] seed_of(input mode_e m);
    return (m == MODE_JOHNSON) ? '0 : WIDTH'(1);
  endfunction

  // Next count, index and wrap for one enabled step in the current direction.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    shifted   = count;
    idx_next  = step_idx;
    wrap_next = 1'b0;
    fb_up     = (mode_q == MODE_JOHNSON) ? ~count[WIDTH-1] : count[WIDTH-1];
    fb_down   = (mode_q == MODE_JOHNSON) ? ~count[0]       : count[0];
    last_idx  = (mode_q == MODE_JOHNSON) ? JOHNSON_LAST    : RING_LAST;
    if (!dir) begin
      shifted   = {count[WIDTH-2:0], fb_up};
      wrap_next = (step_idx == last_idx);
      idx_next  = wrap_next ? '0 : step_idx + IDX_W'(1);
    end else begin
      shifted   = {fb_down, count[WIDTH-1:1]};
      wrap_next = (step_idx == '0);
      idx_next  = wrap_next ? last_idx : step_idx - IDX_W'(1);
    end
  end

  // Illegal-code decode: ring needs exactly one set bit, Johnson at most one
  // adjacent-bit transition (non-circular).
  always_comb begin
    ones  = 0;
    edges = 0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + int'(count[i]);
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      edges = edges + int'(count[i] ^ count[i+1]);
    end
    illegal = (mode_q == MODE_JOHNSON) ? (edges > 1) : (ones != 1);
  end

  // State update with priority rst > mode change > load > en > hold.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    mode_q <= mode_in;
    if (rst) begin
      count    <= seed_of(mode_in);
      step_idx <= '0;
      wrap     <= 1'b0;
    end else if (mode_in != mode_q) begin
      count    <= seed_of(mode_in);
      step_idx <= '0;
      wrap     <= 1'b0;
    end else if (load) begin
      count    <= load_val;
      step_idx <= '0;
      wrap     <= 1'b0;
    end else if (en) begin
`ifdef RINGCNT_SELFCORRECT_EN
      if (illegal) begin
        count    <= seed_of(mode_q);
        step_idx <= '0;
        wrap     <= 1'b0;
      end else begin
        count    <= shifted;
        step_idx <= idx_next;
        wrap     <= wrap_next;
      end
`else
      count    <= shifted;
      step_idx <= idx_next;
      wrap     <= wrap_next;
`endif
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ring_johnson_counter.sv
// tb_ring_johnson_counter
//   Directed scenarios with literal expectations followed by randomized
//   stimulus, all cross-checked every cycle against an arithmetic model of the
//   counter (position modulo period, rotate-with-feedback on integers).
module tb_ring_johnson_counter;

  localparam int W     = 4;
  localparam int IDX_W = $clog2(2*W);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             dir = 1'b0;
  logic             mode = 1'b0;
  logic             load = 1'b0;
  logic [W-1:0]     load_val = '0;
  logic [W-1:0]     count;
  logic [IDX_W-1:0] step_idx;
  logic             wrap;
  logic             illegal;

  int n_checks = 0;
  int n_fail   = 0;

  ring_johnson_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dir      (dir),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .step_idx (step_idx),
    .wrap     (wrap),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int mask = (1 << W) - 1;

  int m_count;
  int m_idx;
  bit m_mode;
  bit m_wrap;
  bit m_valid = 1'b0;

  function automatic int seed_of(input bit md);
    return md ? 0 : 1;
  endfunction

  function automatic bit is_illegal(input int c, input bit md);
    if (md) return $countones((c ^ (c >> 1)) & (mask >> 1)) > 1;
    return $countones(c & mask) != 1;
  endfunction

  function automatic int step_up(input int c, input bit md);
    int msb = (c >> (W - 1)) & 1;
    int fb  = md ? (1 - msb) : msb;
    return ((c << 1) | fb) & mask;
  endfunction

  function automatic int step_down(input int c, input bit md);
    int lsb = c & 1;
    int fb  = md ? (1 - lsb) : lsb;
    return ((c >> 1) | (fb << (W - 1))) & mask;
  endfunction

  always @(posedge clk) begin
    int p;
    p = m_mode ? 2*W : W;
    m_mode <= mode;
    if (rst) begin
      m_count <= seed_of(mode); m_idx <= 0; m_wrap <= 0; m_valid <= 1'b1;
    end else if (mode != m_mode) begin
      m_count <= seed_of(mode); m_idx <= 0; m_wrap <= 0;
    end else if (load) begin
      m_count <= int'(load_val); m_idx <= 0; m_wrap <= 0;
    end else if (en) begin
`ifdef RINGCNT_SELFCORRECT_EN
      if (is_illegal(m_count, m_mode)) begin
        m_count <= seed_of(m_mode); m_idx <= 0; m_wrap <= 0;
      end else
`endif
      if (!dir) begin
        m_count <= step_up(m_count, m_mode);
        m_idx   <= (m_idx + 1) % p;
        m_wrap  <= (m_idx == p - 1);
      end else begin
        m_count <= step_down(m_count, m_mode);
        m_idx   <= (m_idx + p - 1) % p;
        m_wrap  <= (m_idx == 0);
      end
    end else begin
      m_wrap <= 0;
    end
  end

  // Compare process: every cycle once the model has seen a reset.
  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      check("model count",    32'(count),    32'(m_count));
      check("model step_idx", 32'(step_idx), 32'(m_idx));
      check("model wrap",     32'(wrap),     32'(m_wrap));
      check("model illegal",  32'(illegal),  32'(is_illegal(m_count, m_mode)));
    end
  end

  // ---------------- stimulus helpers ----------------
  // Apply inputs at a falling edge and return at the next falling edge.
  task automatic drive(input bit r, input bit e, input bit d, input bit md,
                       input bit ld, input logic [W-1:0] lv);
    rst = r; en = e; dir = d; mode = md; load = ld; load_val = lv;
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input logic [W-1:0] c,
                            input int idx, input bit w);
    check({name, " count"},    32'(count),    32'(c));
    check({name, " step_idx"}, 32'(step_idx), 32'(idx));
    check({name, " wrap"},     32'(wrap),     32'(w));
  endtask

  logic [W-1:0] ring_up [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [W-1:0] john_up [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                4'b1110, 4'b1100, 4'b1000, 4'b0000};

  initial begin
    bit cur_mode;

    // 1: reset into ring, then four up-steps with wrap on the fourth.
    drive(1, 0, 0, 0, 0, '0);
    drive(1, 0, 0, 0, 0, '0);
    expect_out("reset", 4'b0001, 0, 0);
    check("reset illegal", 32'(illegal), 32'(0));
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 0, '0);
      expect_out($sformatf("ring up %0d", i), ring_up[i], (i + 1) % 4, i == 3);
    end

    // 2: switch to Johnson with en=1, then eight steps.
    drive(0, 1, 0, 1, 0, '0);
    expect_out("to johnson", 4'b0000, 0, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 1, 0, '0);
      expect_out($sformatf("johnson up %0d", i), john_up[i], (i + 1) % 8, i == 7);
    end
    drive(0, 1, 1, 1, 0, '0);
    expect_out("johnson down wrap", 4'b1000, 7, 1);
    drive(0, 1, 1, 1, 0, '0);
    expect_out("johnson down", 4'b1100, 6, 0);

    // 3: back to ring seed, step down.
    drive(0, 1, 1, 0, 0, '0);
    expect_out("to ring", 4'b0001, 0, 0);
    drive(0, 1, 1, 0, 0, '0);
    expect_out("ring down wrap", 4'b1000, 3, 1);
    drive(0, 1, 1, 0, 0, '0);
    expect_out("ring down", 4'b0100, 2, 0);

    // 4: hold, then load beats en.
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 0, 0, '0);
      expect_out($sformatf("hold %0d", i), 4'b0100, 2, 0);
    end
    drive(0, 1, 0, 0, 1, 4'b0100);
    expect_out("load over en", 4'b0100, 0, 0);

    // 5: illegal ring code.
    drive(0, 0, 0, 0, 1, 4'b0110);
    check("ring 0110 illegal", 32'(illegal), 32'(1));
    drive(0, 1, 0, 0, 0, '0);
`ifdef RINGCNT_SELFCORRECT_EN
    expect_out("selfcorrect", 4'b0001, 0, 0);
    check("selfcorrect illegal", 32'(illegal), 32'(0));
`else
    expect_out("illegal shift", 4'b1100, 1, 0);
    check("illegal persists", 32'(illegal), 32'(1));
`endif

    // 6: reset mid-Johnson, then mode toggle together with load.
    drive(0, 0, 0, 1, 0, '0);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 1, 0, '0);
    expect_out("johnson 0111", 4'b0111, 3, 0);
    drive(1, 1, 0, 1, 0, '0);
    expect_out("johnson reset", 4'b0000, 0, 0);
    drive(0, 0, 0, 0, 1, 4'b1010);
    expect_out("mode over load", 4'b0001, 0, 0);

    // Johnson illegal decode.
    drive(0, 0, 0, 1, 0, '0);
    drive(0, 0, 0, 1, 1, 4'b0101);
    check("johnson 0101 illegal", 32'(illegal), 32'(1));
    drive(0, 0, 0, 1, 1, 4'b0011);
    check("johnson 0011 legal", 32'(illegal), 32'(0));
    drive(0, 0, 0, 1, 1, 4'b1001);
    check("johnson 1001 illegal", 32'(illegal), 32'(1));

    // Randomized run, checked by the model every cycle.
    cur_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bit r, e, d, ld;
      logic [W-1:0] lv;
      if ($urandom_range(0, 99) < 3) cur_mode = ~cur_mode;
      r  = ($urandom_range(0, 199) == 0);
      ld = ($urandom_range(0, 99) < 6);
      e  = ($urandom_range(0, 99) < 75);
      d  = $urandom_range(0, 1) == 1;
      lv = W'($urandom);
      drive(r, e, d, cur_mode, ld, lv);
    end

    drive(0, 0, 0, cur_mode, 0, '0);
    drive(0, 0, 0, cur_mode, 0, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
